// File: rtl/ram_pkg.sv
// Shared constants and FSM encoding for the burst RAM master.
package ram_pkg;

    localparam int M_DEF = 8;   // data width
    localparam int N_DEF = 8;   // address width
    localparam int L_DEF = 4;   // burst-length field width

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD       = 2'd1,
        RD_DRAIN = 2'd2,
        WR       = 2'd3
    } state_t;

endpackage

// File: rtl/ram_master.sv
// Burst master for a single-port synchronous RAM: accepts read/write burst
// requests and sequences one memory access per beat.
module ram_master
    import ram_pkg::*;
#(
    parameter int M = M_DEF,
    parameter int N = N_DEF,
    parameter int L = L_DEF
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wr,
    input  logic [N-1:0] req_addr,
    input  logic [L-1:0] req_len,

    input  logic         wdata_valid,
    output logic         wdata_ready,
    input  logic [M-1:0] wdata,

    output logic         rdata_valid,
    output logic [M-1:0] rdata,
    output logic         done,

    output logic         mem_cs,
    output logic         mem_rd,
    output logic         mem_wr,
    output logic [N-1:0] mem_addr,
    output logic [M-1:0] mem_wdata,
    input  logic [M-1:0] mem_rdata
);

    state_t       state;
    logic [N-1:0] addr;
    logic [L-1:0] beats_left;
    logic         rd_issued;

    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; a blocking = would let later lines see the new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            beats_left <= '0;
            rd_issued  <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_issued <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr       <= req_addr;
                        beats_left <= req_len;
                        state      <= req_wr ? WR : RD;
                    end
                end
                RD: begin
                    // Reads never stall: one issue per cycle until the count runs out.
                    rd_issued <= 1'b1;
                    addr      <= addr + 1'b1;
                    if (beats_left == '0) begin
                        state <= RD_DRAIN;
                        done  <= 1'b1;  // lines up with the final rdata_valid
                    end else begin
                        beats_left <= beats_left - 1'b1;
                    end
                end
                RD_DRAIN: begin
                    state <= IDLE;
                end
                WR: begin
                    if (wdata_valid) begin
                        addr <= addr + 1'b1;
                        if (beats_left == '0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: each output gets a default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        mem_cs      = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            RD: begin
                mem_cs = 1'b1;
                mem_rd = 1'b1;
            end
            WR: begin
                wdata_ready = 1'b1;
                mem_cs      = wdata_valid;
                mem_wr      = wdata_valid;
            end
            default: ;
        endcase
    end

    assign mem_addr    = addr;
    assign mem_wdata   = wdata;
    assign rdata_valid = rd_issued;
    // The memory returns data one cycle after the read strobe, aligned with rd_issued.
    assign rdata       = mem_rdata;

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master paired with a behavioural synchronous RAM.
module tb_ram_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_wr;
    logic [7:0] req_addr;
    logic [3:0] req_len;
    logic       wdata_valid, wdata_ready;
    logic [7:0] wdata;
    logic       rdata_valid;
    logic [7:0] rdata;
    logic       done;
    logic       mem_cs, mem_rd, mem_wr;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    ram_master #(.M(8), .N(8), .L(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .done        (done),
        .mem_cs      (mem_cs),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Data memory: background pattern addr^0x3C loaded while mem_init is high.
    logic [7:0] mem [256];
    logic       mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
        end else if (mem_cs && mem_wr && !mem_rd) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_cs && mem_rd) mem_rdata <= mem[mem_addr];
        else                  mem_rdata <= 8'h5A;
    end

    function automatic logic [7:0] pattern(input logic [7:0] a);
        return a ^ 8'h3C;
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rq[$];
    int         rc[$];
    int         done_cnt;
    int         done_cyc;
    always @(negedge clk) begin
        if (rdata_valid) begin
            rq.push_back(rdata);
            rc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0] wbuf [16];

    task automatic write_burst(input logic [7:0] a, input logic [3:0] len,
                               input int stall_before, input int stall_n);
        done_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_len = len;
        #1 check("wr_req_ready", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == stall_before) begin
                for (int s = 0; s < stall_n; s++) begin
                    wdata_valid = 1'b0;
                    #1 check("wr_stall_cs", 32'(mem_cs), 0);
                    check("wr_stall_ready", 32'(wdata_ready), 1);
                    @(negedge clk);
                end
            end
            wdata_valid = 1'b1;
            wdata       = wbuf[i];
            #1 check("wr_strobes", 32'({mem_cs, mem_rd, mem_wr}), 32'b101);
            check("wr_addr", 32'(mem_addr), 32'(8'(a + 8'(i))));
            @(negedge clk);
        end
        wdata_valid = 1'b0;
        #1 check("wr_done_pulse", 32'(done), 1);
        check("wr_back_idle", 32'(req_ready), 1);
        @(negedge clk);
        #1 check("wr_done_once", 32'(done_cnt), 1);
    endtask

    task automatic read_burst(input logic [7:0] a, input logic [3:0] len);
        int acc;
        rq.delete();
        rc.delete();
        done_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_len = len;
        #1 check("rd_req_ready", 32'(req_ready), 1);
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        #1 check("rd_strobes", 32'({mem_cs, mem_rd, mem_wr}), 32'b110);
        check("rd_addr0", 32'(mem_addr), 32'(a));
        repeat (int'(len) + 4) @(negedge clk);
        #1 check("rd_beats", 32'(rq.size()), 32'(int'(len) + 1));
        check("rd_done_once", 32'(done_cnt), 1);
        if (rq.size() > 0) begin
            check("rd_first_latency", 32'(rc[0] - acc), 2);
            check("rd_contiguous", 32'(rc[rc.size()-1] - rc[0]), 32'(len));
            check("rd_done_with_last", 32'(done_cyc), 32'(rc[rc.size()-1]));
        end
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [3:0]  len;
        logic [31:0] data;   // beat i in bits [8*i +: 8]
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{wr: 1'b1, addr: 8'h10, len: 4'd0, data: 32'h0000_00A5};
        tbl[1] = '{wr: 1'b0, addr: 8'h10, len: 4'd0, data: 32'h0000_00A5};
        tbl[2] = '{wr: 1'b1, addr: 8'hFE, len: 4'd3, data: 32'h0403_0201};
        tbl[3] = '{wr: 1'b0, addr: 8'hFE, len: 4'd3, data: 32'h0403_0201};

        rst_n = 1'b0; mem_init = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = '0;
        done_cnt = 0; done_cyc = 0;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        rst_n    = 1'b1;
        #1 check("rst_req_ready", 32'(req_ready), 1);
        check("rst_strobes", 32'({mem_cs, mem_rd, mem_wr, wdata_ready}), 0);
        check("rst_rvalid_done", 32'({rdata_valid, done}), 0);

        // Table: single-beat and wrapping bursts, write then read-back
        for (int v = 0; v < 4; v++) begin
            if (tbl[v].wr) begin
                for (int i = 0; i <= int'(tbl[v].len); i++) wbuf[i] = tbl[v].data[8*i +: 8];
                write_burst(tbl[v].addr, tbl[v].len, -1, 0);
                for (int i = 0; i <= int'(tbl[v].len); i++)
                    check("tbl_mem", 32'(mem[8'(tbl[v].addr + 8'(i))]), 32'(tbl[v].data[8*i +: 8]));
            end else begin
                read_burst(tbl[v].addr, tbl[v].len);
                for (int i = 0; i < rq.size() && i <= int'(tbl[v].len); i++)
                    check("tbl_rdata", 32'(rq[i]), 32'(tbl[v].data[8*i +: 8]));
            end
        end

        // Write with a 3-cycle wdata_valid gap before beat 1
        wbuf[0] = 8'h31; wbuf[1] = 8'h32; wbuf[2] = 8'h33;
        write_burst(8'h20, 4'd2, 1, 3);
        check("stall_mem0", 32'(mem[8'h20]), 32'h31);
        check("stall_mem1", 32'(mem[8'h21]), 32'h32);
        check("stall_mem2", 32'(mem[8'h22]), 32'h33);
        check("stall_mem3", 32'(mem[8'h23]), 32'(pattern(8'h23)));

        // Longest burst over background data
        read_burst(8'h80, 4'd15);
        for (int i = 0; i < rq.size() && i < 16; i++)
            check("rd16_data", 32'(rq[i]), 32'(pattern(8'(8'h80 + 8'(i)))));

        // Reset during beat 2 of an 8-beat write
        done_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h40; req_len = 4'd7;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata_valid = 1'b1; wdata = 8'(8'h11 * (i + 1));
            @(negedge clk);
        end
        wdata_valid = 1'b1; wdata = 8'h33;
        #2 rst_n = 1'b0;
        #1 check("rstmid_strobes", 32'({mem_cs, mem_rd, mem_wr, wdata_ready}), 0);
        check("rstmid_rvalid_done", 32'({rdata_valid, done}), 0);
        @(negedge clk);
        wdata_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("rstmid_no_done", 32'(done_cnt), 0);
        check("rstmid_ready", 32'(req_ready), 1);
        check("rstmid_beat0", 32'(mem[8'h40]), 32'h11);
        check("rstmid_beat1", 32'(mem[8'h41]), 32'h22);
        for (int i = 2; i < 8; i++)
            check("rstmid_untouched", 32'(mem[8'(8'h40 + 8'(i))]), 32'(pattern(8'(8'h40 + 8'(i)))));

        // Request held high: second burst only in the first IDLE cycle after the first
        done_cnt = 0;
        rq.delete();
        rc.delete();
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h10; req_len = 4'd1;
        for (int k = 0; k < 6; k++) begin
            #1 check("b2b_ready", 32'(req_ready), (k == 0 || k == 4) ? 1 : 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 check("b2b_done_count", 32'(done_cnt), 2);
        check("b2b_beats", 32'(rq.size()), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
